// File: rtl/key_debounce_ctrl.sv
// key_debounce_ctrl: per-key synchronise and debounce, press-event pending/mask registers
// with a level interrupt and a four-word register file.
module key_debounce_ctrl #(
   parameter int N_KEYS     = 8,
   parameter int DB_CNT     = 1000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_in,
   input  logic [1:0]        addr,
   input  logic              we,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              irq
);
   localparam int CW = $clog2(DB_CNT + 1);
   localparam logic [CW-1:0] LAST = CW'(DB_CNT - 1);
   localparam logic [31:0] INFO = {16'd0, 8'(DB_CNT >= 256 ? 255 : DB_CNT), 8'(N_KEYS)};

   logic [N_KEYS-1:0] p, s1_q, s_q, d_q, d_d, dp_q, pend_q, pend_d, mask_q, mask_d, clr;
   logic [CW-1:0]     cnt_q [N_KEYS];
   logic [CW-1:0]     cnt_d [N_KEYS];
   logic              irq_q;
   logic              unused_wdata;

   assign p = (ACTIVE_LOW != 0) ? ~key_in : key_in;
   assign unused_wdata = ^wdata;

   always_comb begin
      for (int i = 0; i < N_KEYS; i++) begin
         cnt_d[i] = (s_q[i] == d_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + CW'(1);
         d_d[i]   = (s_q[i] != d_q[i] && cnt_q[i] == LAST) ? s_q[i] : d_q[i];
      end
   end

   // d_q & ~dp_q is the press event one cycle after d rises; it beats a same-cycle W1C
   assign clr    = (we && addr == 2'd1) ? wdata[N_KEYS-1:0] : '0;
   assign pend_d = (pend_q & ~clr) | (d_q & ~dp_q);
   assign mask_d = (we && addr == 2'd2) ? wdata[N_KEYS-1:0] : mask_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= '0;
         s_q    <= '0;
         d_q    <= '0;
         dp_q   <= '0;
         pend_q <= '0;
         mask_q <= '0;
         irq_q  <= 1'b0;
         for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
      end else begin
         s1_q   <= p;
         s_q    <= s1_q;
         d_q    <= d_d;
         dp_q   <= d_q;
         pend_q <= pend_d;
         mask_q <= mask_d;
         irq_q  <= |(pend_q & mask_q);
         cnt_q  <= cnt_d;
      end
   end

   assign irq   = irq_q;
   assign rdata = (addr == 2'd0) ? 32'(d_q) :
                  (addr == 2'd1) ? 32'(pend_q) :
                  (addr == 2'd2) ? 32'(mask_q) : INFO;
endmodule

// File: tb/tb_key_debounce_ctrl.sv
// tb_key_debounce_ctrl: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model of the debouncer and register file.
module tb_key_debounce_ctrl;
   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  key_in = 8'hFF;
   logic [1:0]  addr = 2'd0;
   logic        we = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_p0, m_p1, m_d, m_pend, m_mask, m_rose;
   logic       m_irq;
   int         m_run [8];

   key_debounce_ctrl #(.N_KEYS(8), .DB_CNT(DB), .ACTIVE_LOW(1)) dut (
      .clk(clk), .reset(reset), .key_in(key_in), .addr(addr), .we(we),
      .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   always #5 clk = ~clk;

   // model: s is the pressed level seen two edges ago; d takes s once s has
   // disagreed with d for DB edges in a row; a rise of d sets PENDING one edge later
   task automatic model_step();
      logic [7:0] s, d_old, clr;
      if (reset) begin
         m_p0 = 0; m_p1 = 0; m_d = 0; m_pend = 0; m_mask = 0; m_rose = 0; m_irq = 0;
         for (int i = 0; i < 8; i++) m_run[i] = 0;
      end else begin
         s = m_p1;
         m_p1 = m_p0;
         m_p0 = ~key_in;
         d_old = m_d;
         for (int i = 0; i < 8; i++) begin
            m_run[i] = (s[i] != m_d[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == DB) begin
               m_d[i] = s[i];
               m_run[i] = 0;
            end
         end
         m_irq = |(m_pend & m_mask);
         clr = (we && addr == 2'd1) ? wdata[7:0] : 8'h00;
         m_pend = (m_pend & ~clr) | m_rose;
         if (we && addr == 2'd2) m_mask = wdata[7:0];
         m_rose = m_d & ~d_old;
      end
   endtask

   function automatic logic [31:0] model_rdata(input logic [1:0] a);
      case (a)
         2'd0: return {24'd0, m_d};
         2'd1: return {24'd0, m_pend};
         2'd2: return {24'd0, m_mask};
         default: return 32'h0000_0408;
      endcase
   endfunction

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_step();
         #1;
      end
   endtask

   task automatic do_reset();
      key_in = 8'hFF; we = 0; reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic write(input logic [1:0] a, input logic [31:0] v);
      addr = a; wdata = v; we = 1;
      tick();
      we = 0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int a = 0; a < 3; a++) begin
         addr = 2'(a); #1;
         checks++;
         if (rdata !== 32'd0) begin
            errors++; $display("FAIL reset_reg%0d got %h exp 0", a, rdata);
         end
      end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
   endtask

   task automatic test_clean_press();
      do_reset();
      key_in = 8'hFE;
      tick(5);
      addr = 0; #1; checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL press_state_c5 got %h exp 0", rdata); end
      tick();
      addr = 0; #1; checks++;
      if (rdata !== 32'h1) begin errors++; $display("FAIL press_state_c6 got %h exp 1", rdata); end
      addr = 1; #1; checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL press_pend_c6 got %h exp 0", rdata); end
      tick();
      addr = 1; #1; checks++;
      if (rdata !== 32'h1) begin errors++; $display("FAIL press_pend_c7 got %h exp 1", rdata); end
      key_in = 8'hFF;
      tick(8);
      addr = 0; #1; checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL release_state got %h exp 0", rdata); end
      addr = 1; #1; checks++;
      if (rdata !== 32'h1) begin errors++; $display("FAIL release_pend got %h exp 1", rdata); end
   endtask

   task automatic test_glitch();
      do_reset();
      key_in = 8'hFE;
      tick(3);
      key_in = 8'hFF;
      tick(10);
      addr = 0; #1; checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL glitch_state got %h exp 0", rdata); end
      addr = 1; #1; checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL glitch_pend got %h exp 0", rdata); end
   endtask

   task automatic test_interrupt();
      do_reset();
      write(2'd2, 32'h1);
      key_in = 8'hFE;
      tick(7);
      addr = 1; #1; checks++;
      if (rdata !== 32'h1) begin errors++; $display("FAIL irq_pend got %h exp 1", rdata); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
      tick();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
      write(2'd1, 32'h1);
      addr = 1; #1; checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL irq_w1c_pend got %h exp 0", rdata); end
      tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
      key_in = 8'hFF;
   endtask

   task automatic test_collision();
      do_reset();
      key_in = 8'hFB;
      tick(6);
      write(2'd1, 32'h4);
      addr = 1; #1; checks++;
      if (rdata !== 32'h4) begin errors++; $display("FAIL collision_pend got %h exp 4", rdata); end
      key_in = 8'hFF;
   endtask

   task automatic test_reset_mid();
      do_reset();
      write(2'd2, 32'hFF);
      key_in = 8'hFE;
      tick(4);
      reset = 1; we = 1; addr = 2'd2; wdata = 32'hFF;
      tick();
      reset = 0; we = 0;
      for (int a = 0; a < 3; a++) begin
         addr = 2'(a); #1; checks++;
         if (rdata !== 32'd0) begin errors++; $display("FAIL rstmid_reg%0d got %h exp 0", a, rdata); end
      end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq got %b exp 0", irq); end
      tick(6);
      addr = 1; #1; checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL rstmid_pend_c6 got %h exp 0", rdata); end
      tick();
      addr = 1; #1; checks++;
      if (rdata !== 32'h1) begin errors++; $display("FAIL rstmid_pend_c7 got %h exp 1", rdata); end
      key_in = 8'hFF;
   endtask

   task automatic test_reads();
      do_reset();
      addr = 3; #1; checks++;
      if (rdata !== 32'h0000_0408) begin errors++; $display("FAIL info got %h exp 00000408", rdata); end
      write(2'd2, 32'hFFFF_FF0F);
      addr = 2; #1; checks++;
      if (rdata !== 32'h0000_000F) begin errors++; $display("FAIL mask_rb got %h exp 0000000f", rdata); end
      write(2'd0, 32'hFFFF_FFFF);
      addr = 0; #1; checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL state_ro got %h exp 0", rdata); end
      write(2'd3, 32'h0);
      addr = 3; #1; checks++;
      if (rdata !== 32'h0000_0408) begin errors++; $display("FAIL info_ro got %h exp 00000408", rdata); end
   endtask

   task automatic test_random();
      logic [31:0] exp;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int a = 0; a < 4; a++) begin
            addr = 2'(a); #1;
            exp = model_rdata(2'(a));
            checks++;
            if (rdata !== exp) begin
               errors++; $display("FAIL rand_reg%0d cyc %0d got %h exp %h", a, c, rdata, exp);
            end
         end
         checks++;
         if (irq !== m_irq) begin errors++; $display("FAIL rand_irq cyc %0d got %b exp %b", c, irq, m_irq); end
         if ($urandom_range(0, 4) == 0) key_in = key_in ^ 8'($urandom);
         reset = ($urandom_range(0, 99) == 0);
         we = ($urandom_range(0, 5) == 0);
         addr = 2'($urandom);
         wdata = $urandom;
         tick();
      end
      reset = 0; we = 0;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_interrupt();
      test_collision();
      test_reset_mid();
      test_reads();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
